// File: rtl/fb_pkg.sv
//------------------------------------------------------------------------------
// Module  : fb_pkg
// Purpose : Shared frame-buffer geometry, pixel type and arbiter state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

    localparam int FB_W  = 256;
    localparam int FB_H  = 240;
    localparam int COL_W = 6;

    localparam logic [7:0] X_LAST = 8'(FB_W - 1);
    localparam logic [7:0] Y_LAST = 8'(FB_H - 1);

    typedef struct packed {
        logic [7:0]       x;
        logic [7:0]       y;
        logic [COL_W-1:0] col;
    } fb_pix_t;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } fb_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/fb_clear_walker.sv
//------------------------------------------------------------------------------
// Module  : fb_clear_walker
// Purpose : Raster-order (x fastest) coordinate counter over a rectangular area.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fb_clear_walker
    import fb_pkg::*;
#(
    parameter logic [7:0] X_MAX = X_LAST,
    parameter logic [7:0] Y_MAX = Y_LAST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       advance,
    output logic [7:0] cx,
    output logic [7:0] cy,
    output logic       last
);

    assign last = (cx == X_MAX) && (cy == Y_MAX);

    // start wins over advance so a restart always begins at the origin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx <= 8'd0;
            cy <= 8'd0;
        end else if (start) begin
            cx <= 8'd0;
            cy <= 8'd0;
        end else if (advance) begin
            if (cx == X_MAX) begin
                cx <= 8'd0;
                cy <= (cy == Y_MAX) ? 8'd0 : cy + 8'd1;
            end else begin
                cx <= cx + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fb_write_arbiter.sv
//------------------------------------------------------------------------------
// Module  : fb_write_arbiter
// Purpose : Shares the vga_fb write port between PPU, host writer and clear engine.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int STARVE_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ppu_valid,
    output logic             ppu_ready,
    input  logic [7:0]       ppu_x,
    input  logic [7:0]       ppu_y,
    input  logic [COL_W-1:0] ppu_col,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [7:0]       host_x,
    input  logic [7:0]       host_y,
    input  logic [COL_W-1:0] host_col,
    input  logic             clr_req,
    input  logic [COL_W-1:0] clr_col,
    output logic             clr_busy,
    output logic             clr_done,
    output logic [7:0]       fb_x,
    output logic [7:0]       fb_y,
    output logic [COL_W-1:0] fb_DI,
    output logic             fb_CS,
    output logic             oob_err
);

    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    fb_arb_state_t    r_state;
    fb_arb_state_t    w_state_next;
    logic [SC_W-1:0]  r_starve_cnt;
    logic [COL_W-1:0] r_clr_col;

    logic             w_in_arb;
    logic             w_starved;
    logic             w_ppu_hs;
    logic             w_host_hs;
    logic             w_clr_start;
    logic             w_clr_adv;
    logic             w_wr_en;
    fb_pix_t          w_wr_pix;

    logic [7:0]       w_cx;
    logic [7:0]       w_cy;
    logic             w_last;

    assign w_in_arb  = (r_state == ARB);
    assign w_starved = (r_starve_cnt == STARVE_MAX);

    // Grant rules guarantee at most one handshake per cycle
    assign ppu_ready  = w_in_arb && !(w_starved && host_valid);
    assign host_ready = w_in_arb && (!ppu_valid || w_starved);
    assign w_ppu_hs   = ppu_valid && ppu_ready;
    assign w_host_hs  = host_valid && host_ready;

    fb_clear_walker #(
        .X_MAX (X_LAST),
        .Y_MAX (Y_LAST)
    ) u_walker (
        .clk     (clk),
        .rst     (rst),
        .start   (w_clr_start),
        .advance (w_clr_adv),
        .cx      (w_cx),
        .cy      (w_cy),
        .last    (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr_start  = 1'b0;
        w_clr_adv    = 1'b0;
        case (r_state)
            ARB: begin
                if (clr_req) begin
                    w_state_next = CLEAR;
                    w_clr_start  = 1'b1;
                end
            end
            CLEAR: begin
                w_clr_adv = 1'b1;
                if (w_last) begin
                    w_state_next = ARB;
                end
            end
            default: w_state_next = ARB;
        endcase
    end

    // Write source select; handshakes cannot occur while clearing
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_pix = '0;
        if (r_state == CLEAR) begin
            w_wr_en  = 1'b1;
            w_wr_pix = '{x: w_cx, y: w_cy, col: r_clr_col};
        end else if (w_host_hs) begin
            w_wr_en  = 1'b1;
            w_wr_pix = '{x: host_x, y: host_y, col: host_col};
        end else if (w_ppu_hs) begin
            w_wr_en  = 1'b1;
            w_wr_pix = '{x: ppu_x, y: ppu_y, col: ppu_col};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_in_arb) begin
            if (w_host_hs) begin
                r_starve_cnt <= '0;
            end else if (host_valid && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_col <= '0;
        end else if (w_clr_start) begin
            r_clr_col <= clr_col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_x     <= 8'd0;
            fb_y     <= 8'd0;
            fb_DI    <= '0;
            fb_CS    <= 1'b0;
            oob_err  <= 1'b0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            if (w_wr_en) begin
                fb_x  <= w_wr_pix.x;
                fb_y  <= w_wr_pix.y;
                fb_DI <= w_wr_pix.col;
            end
            fb_CS    <= w_wr_en && (w_wr_pix.y <= Y_LAST);
            oob_err  <= w_wr_en && (w_wr_pix.y > Y_LAST);
            clr_busy <= (w_state_next == CLEAR);
            clr_done <= (r_state == CLEAR) && w_last;
        end
    end

endmodule

`default_nettype wire
